uart_receiver: RTL and testbench
================================

# uart_receiver

Asynchronous serial receiver for the `uart` peripheral: samples the `rx` pin, decodes 8N1 frames (8E1/8O1 with parity compiled in), and delivers each byte with a one-cycle valid strobe. It is the receive end of the line driven by the UART transmitter and uses the same `prescale` bit-period control. It sits between the pad and the MCU's UART register interface.

## Interface
- `DATA_BITS`, 8, data bits per frame, LSB first.
- `SYNC_STAGES`, 2, flip-flops in the `rx` input synchronizer (minimum 2).
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `prescale`  in  16  clock cycles per bit period; sampled only at start-bit detection.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_data`  out  DATA_BITS  last correctly received byte; reset 0.
- `rx_valid`  out  1  one-cycle pulse, `rx_data` newly updated; reset 0.
- `rx_busy`  out  1  high in any state other than IDLE; reset 0.
- `rx_error`  out  1  one-cycle pulse on framing or parity error; reset 0.

## Operation
- `rx` passes through SYNC_STAGES flops; the synchronizer resets to 1 (idle). All decoding uses the synchronized value `rxs`.
- Effective period is P = max(`prescale`, 4), latched into a 16-bit register at detection. A change to `prescale` mid-frame has no effect until the next frame.
- State machine:
  - IDLE: on a 1→0 transition of `rxs`, load the down-counter with floor(P/2) and go to START.
  - START: when the counter reaches 0, sample. If `rxs`=1, treat it as a false start and return to IDLE with no pulse. Otherwise reload P and go to DATA.
  - DATA: sample every P cycles and shift into the shift register LSB first. After DATA_BITS samples, go to PARITY (if enabled) or STOP.
  - PARITY: sample one bit and compare it with the XOR of the data bits, inverted if PARITY_ODD. Record the mismatch and go to STOP.
  - STOP: sample.
    - If `rxs`=1 and no parity mismatch, copy the shift register to `rx_data`, pulse `rx_valid` and return to IDLE.
    - Otherwise pulse `rx_error`, leave `rx_data` unchanged and go to WAIT_IDLE.
  - WAIT_IDLE: remain until `rxs`=1, then go to IDLE. This covers a break condition (line held low) without re-triggering.
- `rx_valid` and `rx_error` are never high in the same cycle.
- Back-to-back frames: a start edge is accepted in the first cycle IDLE is re-entered after a stop sample.
- Reset asserted mid-frame: all state, outputs and the synchronizer return to their reset values immediately. The partial frame is discarded.

## Timing
- Detection cycle t0 is the first cycle in which `rxs`=0 after `rxs`=1 in IDLE. Pin-to-`rxs` latency is SYNC_STAGES cycles.
- The start sample occurs at t0+floor(P/2). Sample k (k=1..N) occurs at t0+floor(P/2)+k·P, where N = DATA_BITS+1, or DATA_BITS+2 with parity.
- `rx_valid`/`rx_error` are asserted in the cycle after the stop sample, for exactly one cycle, registered.
- `rx_busy` rises in t0+1 and falls in the same cycle the valid/error pulse is asserted. If the state machine enters WAIT_IDLE, `rx_busy` stays high until WAIT_IDLE exits.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: a parity bit follows the data bits, the PARITY state exists, and a mismatch raises `rx_error`.
  - Undefined: there is no PARITY state, the frame is DATA_BITS+2 bits, and `PARITY_ODD` is ignored.

## Structure
- Shared package `uart_pkg`:
  - the receiver state enum typedef (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - `UART_PRESCALE_MIN` = 4;
  - the prescale width constant (16), so the transmitter and receiver agree.
- One sub-module, `uart_sync`: a parameterized N-stage synchronizer with reset value 1, reusable for other asynchronous pins.

## Test plan
- P=16, frame 0xA5 8N1, idle high → `rx_data`=0xA5, `rx_valid` one cycle at t0+153, `rx_error` stays 0.
- P=16, `rx` low for 5 cycles then high → false start: no pulse, back in IDLE with `rx_busy` low by t0+9.
- P=16, 0x3C with stop bit 0, line then held low 40 bit-times → one `rx_error` pulse, `rx_data` keeps its previous value, no new frame until `rx` returns high.
- `prescale`=2 → behaves as P=4; `prescale` changed from 16 to 32 mid-frame → frame decoded at 16, next frame at 32.
- Parity build, PARITY_ODD=0: 0x07 with parity bit 1 → `rx_valid`; same frame with parity 0 → `rx_error`.
- `reset` pulsed low during DATA of 0xFF, then a clean 0x81 → 0x81 received, no stale pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, prescale width and minimum
// bit period, so the transmitter and receiver agree on bit-period control.
package uart_pkg;

  localparam int UART_PRESCALE_W = 16;
  localparam logic [UART_PRESCALE_W-1:0] UART_PRESCALE_MIN = UART_PRESCALE_W'(4);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // Bit period actually used: the requested prescale clamped to the minimum.
  function automatic logic [UART_PRESCALE_W-1:0] uart_eff_period(
    input logic [UART_PRESCALE_W-1:0] p
  );
    return (p < UART_PRESCALE_MIN) ? UART_PRESCALE_MIN : p;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// N-stage synchronizer for an asynchronous input pin; every stage resets to 1
// so an idle-high line does not produce a spurious edge out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8N1 frames by default; define UART_RX_PARITY_EN to add a
// parity bit (sense set by PARITY_ODD) checked before the stop bit.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [UART_PRESCALE_W-1:0] prescale,
  input  logic                       rx,
  output logic [DATA_BITS-1:0]       rx_data,
  output logic                       rx_valid,
  output logic                       rx_busy,
  output logic                       rx_error
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rxs;
  logic rxs_prev_q;

  uart_rx_state_t              state_q, state_d;
  logic [UART_PRESCALE_W-1:0]  cnt_q, cnt_d;
  logic [UART_PRESCALE_W-1:0]  period_q, period_d;
  logic [UART_PRESCALE_W-1:0]  eff_period;
  logic [BW-1:0]               bit_q, bit_d;
  logic [DATA_BITS-1:0]        shift_q, shift_d;
  logic [DATA_BITS-1:0]        data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        error_q, error_d;
  logic                        tick;
  logic                        stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                        par_q, par_d;
  logic                        par_err_q, par_err_d;
`endif

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_ni(reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  assign eff_period = uart_eff_period(prescale);
  assign tick       = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    par_err_d = par_err_q;
    stop_ok   = rxs && !par_err_q;
`else
    stop_ok   = rxs;
`endif
    case (state_q)
      IDLE: begin
        // Counter runs down to zero, so loading n-1 puts the sample n cycles out.
        if (rxs_prev_q && !rxs) begin
          period_d = eff_period;
          cnt_d    = (eff_period >> 1) - 1'b1;
          state_d  = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (rxs) begin
          state_d = IDLE;
        end else begin
          cnt_d   = period_q - 1'b1;
          bit_d   = '0;
          state_d = DATA;
`ifdef UART_RX_PARITY_EN
          par_d     = (PARITY_ODD != 0);
          par_err_d = 1'b0;
`endif
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = period_q - 1'b1;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_d = par_q ^ rxs;
`endif
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d     = period_q - 1'b1;
          par_err_d = (rxs != par_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - 1'b1;
        end else if (stop_ok) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          error_d = 1'b1;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rxs_prev_q <= 1'b1;
      cnt_q      <= '0;
      period_q   <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rxs_prev_q <= rxs;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_error = error_q;
  assign rx_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: each driven frame queues its expected
// outcome and pulse cycle; a monitor pops and checks on every valid/error pulse.
module tb_uart_receiver;

  logic        clk;
  logic        reset;
  logic [15:0] prescale;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        rx_error;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] last_good = 8'h00;

  uart_receiver dut (
    .clk     (clk),
    .reset   (reset),
    .prescale(prescale),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_busy (rx_busy),
    .rx_error(rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rx_valid || rx_error) begin
      check("exclusive", 32'(rx_valid & rx_error), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(rx_error), 32'(e.err));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.err) begin
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("busy_at_valid", 32'(rx_busy), 32'd0);
          last_good = e.data;
          $display("[TB] cycle %0d: rx_valid data=0x%02h", cyc, rx_data);
        end else begin
          check("data_kept", 32'(rx_data), 32'(last_good));
          check("busy_at_error", 32'(rx_busy), 32'd1);
          $display("[TB] cycle %0d: rx_error data=0x%02h", cyc, rx_data);
        end
      end
    end
  end

  // par < 0 means no parity bit; even parity is assumed for the parity build.
  task automatic send_frame(input logic [7:0] d, input int ps, input int par,
                            input bit stop, input int mid_ps);
    int   p;
    int   n;
    exp_t e;
    p = (ps < 4) ? 4 : ps;
    n = (par >= 0) ? 10 : 9;
    prescale = 16'(ps);
    @(negedge clk);
    e.err  = !stop || ((par >= 0) && (par[0] != ^d));
    e.data = d;
    e.cyc  = cyc + 3 + p / 2 + n * p;
    sb.push_back(e);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 3 && mid_ps > 0) prescale = 16'(mid_ps);
      repeat (p) @(negedge clk);
    end
    if (par >= 0) begin
      rx = par[0];
      repeat (p) @(negedge clk);
    end
    rx = stop;
    repeat (p) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    reset    = 1'b0;
    rx       = 1'b1;
    prescale = 16'd16;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(rx_data), 32'd0);
    check("reset_valid", 32'(rx_valid), 32'd0);
    check("reset_busy", 32'(rx_busy), 32'd0);
    check("reset_error", 32'(rx_error), 32'd0);
    reset = 1'b1;
    idle(5);

    send_frame(8'hA5, 16, -1, 1'b1, 0);
    idle(10);

    // False start: rxs low for t0..t0+4, start sample at t0+8 sees idle.
    @(negedge clk);
    k  = cyc;
    rx = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 3) check("busy_rise", 32'(rx_busy), 32'd1);
      if (i == 5) rx = 1'b1;
    end
    check("false_start_idle", 32'(rx_busy), 32'd0);
    $display("[TB] false start from cycle %0d: busy=%0b", k, rx_busy);
    idle(10);

    // Framing error followed by a 40 bit-time break.
    send_frame(8'h3C, 16, -1, 1'b0, 0);
    repeat (20 * 16) @(negedge clk);
    check("break_busy", 32'(rx_busy), 32'd1);
    repeat (20 * 16) @(negedge clk);
    idle(4);
    check("break_released", 32'(rx_busy), 32'd0);
    $display("[TB] break released: busy=%0b", rx_busy);

    send_frame(8'h5A, 2, -1, 1'b1, 0);
    idle(4);
    send_frame(8'hC3, 16, -1, 1'b1, 32);
    idle(4);
    send_frame(8'h96, 32, -1, 1'b1, 0);
    // Back-to-back: next start edge immediately after the stop bit.
    send_frame(8'h01, 16, -1, 1'b1, 0);
    send_frame(8'h80, 16, -1, 1'b1, 0);
    idle(4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 16, 1, 1'b1, 0);
    idle(4);
    send_frame(8'h07, 16, 0, 1'b1, 0);
    idle(4);
`endif

    for (int i = 0; i < 4; i++) begin
      send_frame(8'($urandom_range(0, 255)), 4 + 4 * i, -1, 1'b1, 0);
      idle(3);
    end

    // Reset in the middle of 0xFF's data bits; the frame must vanish.
    while (sb.size() != 0 && cyc < 40000) @(negedge clk);
    prescale = 16'd16;
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (48) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy", 32'(rx_busy), 32'd0);
    check("midreset_data", 32'(rx_data), 32'd0);
    last_good = 8'h00;
    @(negedge clk);
    reset = 1'b1;
    idle(200);
    send_frame(8'h81, 16, -1, 1'b1, 0);
    idle(10);

    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    idle(20);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
